// File: rtl/dump_serializer_if.sv
// dump_serializer_if: start/select, content buses, UART write port and status of the dump serializer
interface dump_serializer_if #(
  parameter int DATA_BUS_SIZE  = 32,
  parameter int REG_COUNT      = 32,
  parameter int MEM_COUNT      = 32,
  parameter int UART_DATA_BITS = 8
) ();
  logic                               start;
  logic [1:0]                         sel;
  logic [REG_COUNT*DATA_BUS_SIZE-1:0] registers_content;
  logic [MEM_COUNT*DATA_BUS_SIZE-1:0] memory_content;
  logic                               uart_full;
  logic                               uart_wr;
  logic [UART_DATA_BITS-1:0]          uart_data_wr;
  logic                               busy;
  logic                               done;
  modport master (output start, sel, registers_content, memory_content, uart_full,
                  input uart_wr, uart_data_wr, busy, done);
  modport slave (input start, sel, registers_content, memory_content, uart_full,
                 output uart_wr, uart_data_wr, busy, done);
endinterface

// File: rtl/dump_serializer.sv
// dump_serializer: snapshots register bank / data memory and streams it as bytes to the UART TX FIFO
// Optional DUMP_CHECKSUM_EN appends an XOR checksum byte after each section.
module dump_serializer #(
  parameter int DATA_BUS_SIZE  = 32,
  parameter int REG_COUNT      = 32,
  parameter int MEM_COUNT      = 32,
  parameter int UART_DATA_BITS = 8
) (
  input logic              clk,
  input logic              rst_n,
  dump_serializer_if.slave bus
);
  localparam int BPW       = DATA_BUS_SIZE / UART_DATA_BITS;
  localparam int REG_BYTES = REG_COUNT * BPW;
  localparam int MEM_BYTES = MEM_COUNT * BPW;
  localparam int CW        = $clog2((REG_COUNT + MEM_COUNT) * DATA_BUS_SIZE / UART_DATA_BITS + 2);
`ifdef DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t                             state, next;
  logic [CW-1:0]                      cnt;
  logic                               sec, both, last;
  logic [REG_COUNT*DATA_BUS_SIZE-1:0] reg_snap;
  logic [MEM_COUNT*DATA_BUS_SIZE-1:0] mem_snap;
  logic [DATA_BUS_SIZE-1:0]           word;
  logic [UART_DATA_BITS-1:0]          data_byte, out_byte;
  // cnt indexes bytes within the current section; sec=0 registers, sec=1 memory
  always_comb begin
    word      = sec ? mem_snap[(int'(cnt) / BPW) * DATA_BUS_SIZE +: DATA_BUS_SIZE]
                    : reg_snap[(int'(cnt) / BPW) * DATA_BUS_SIZE +: DATA_BUS_SIZE];
    data_byte = word[(BPW - 1 - int'(cnt) % BPW) * UART_DATA_BITS +: UART_DATA_BITS];
    last      = int'(cnt) == (sec ? MEM_BYTES : REG_BYTES) - 1 + CK;
  end
`ifdef DUMP_CHECKSUM_EN
  logic [UART_DATA_BITS-1:0] csum;
  assign out_byte = int'(cnt) == (sec ? MEM_BYTES : REG_BYTES) ? csum : data_byte;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if (state == IDLE || (bus.uart_wr && last)) csum <= '0;
    else if (bus.uart_wr) csum <= csum ^ data_byte;
`else
  assign out_byte = data_byte;
`endif
  assign bus.uart_wr      = state == SEND && !bus.uart_full;
  assign bus.uart_data_wr = state == SEND ? out_byte : '0;
  assign bus.busy         = state == LOAD || state == SEND;
  assign bus.done         = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (state == IDLE && bus.start) next = LOAD;
    if (state == LOAD) next = SEND;
    if (state == SEND && bus.uart_wr && last && !(both && !sec)) next = DONE;
    if (state == DONE) next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      sec      <= 1'b0;
      both     <= 1'b0;
      reg_snap <= '0;
      mem_snap <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        sec  <= bus.sel == 2'b01;
        both <= bus.sel[1];
        cnt  <= '0;
      end
      if (state == LOAD) begin
        if (!sec) reg_snap <= bus.registers_content;
        if (sec || both) mem_snap <= bus.memory_content;
      end
      if (bus.uart_wr) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) sec <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dump_serializer.sv
// tb_dump_serializer: randomized self-checking bench for dump_serializer against a byte-stream model
module tb_dump_serializer;
  localparam int DBS = 32, RC = 32, MC = 32, UDB = 8, BPW = DBS / UDB;
`ifdef DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dump_serializer_if #(.DATA_BUS_SIZE(DBS), .REG_COUNT(RC), .MEM_COUNT(MC), .UART_DATA_BITS(UDB)) bus ();
  dump_serializer #(.DATA_BUS_SIZE(DBS), .REG_COUNT(RC), .MEM_COUNT(MC), .UART_DATA_BITS(UDB))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, wr_nobusy = 0;
  logic [UDB-1:0] got[$];
  int             wr_cyc[$];
  logic [UDB-1:0] exp_q[$];
  logic [DBS-1:0] regs[RC];
  logic [DBS-1:0] mem[MC];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) begin
      if (bus.uart_wr) begin
        got.push_back(bus.uart_data_wr);
        wr_cyc.push_back(cyc);
        if (!bus.busy) wr_nobusy++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_content();
    for (int k = 0; k < RC; k++) bus.registers_content[k*DBS +: DBS] = regs[k];
    for (int k = 0; k < MC; k++) bus.memory_content[k*DBS +: DBS] = mem[k];
  endtask

  task automatic load_content(input bit rnd);
    for (int k = 0; k < RC; k++) regs[k] = rnd ? DBS'($urandom) : '0;
    for (int k = 0; k < MC; k++) mem[k] = rnd ? DBS'($urandom) : '0;
  endtask

  // Expected stream: registers (unless 01), then memory (unless 00); word 0 first, MSB byte first
  task automatic build_exp(input logic [1:0] s);
    logic [DBS-1:0] w;
    logic [UDB-1:0] by, ck;
    exp_q.delete();
    for (int sct = 0; sct < 2; sct++) begin
      if ((sct == 0 && s == 2'b01) || (sct == 1 && s == 2'b00)) continue;
      ck = '0;
      for (int k = 0; k < (sct == 1 ? MC : RC); k++) begin
        w = sct == 1 ? mem[k] : regs[k];
        for (int b = BPW - 1; b >= 0; b--) begin
          by = w[b*UDB +: UDB];
          exp_q.push_back(by);
          ck ^= by;
        end
      end
      if (CK == 1) exp_q.push_back(ck);
    end
  endtask

  task automatic start_dump(input logic [1:0] s, output int st);
    @(posedge clk); #1;
    bus.sel   = s;
    bus.start = 1'b1;
    st        = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_dump(input logic [1:0] s, input bit rand_bp, input int hold_at, input bit mutate,
                          input bit restart, output int base, output int st, output int n,
                          output int bad, output int dd, output int hold_bad);
    int d0;
    bit held;
    held     = 1'b0;
    base     = got.size();
    d0       = done_cnt;
    hold_bad = 0;
    start_dump(s, st);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (mutate && i == 0) bus.registers_content[DBS-1:0] = '0;
      bus.start = restart && i == 30;
      if (hold_at >= 0 && !held && got.size() - base == hold_at) begin
        held = 1'b1;
        bus.uart_full = 1'b1;
        for (int h = 0; h < 10; h++) begin
          @(negedge clk);
          if (bus.uart_wr !== 1'b0 || bus.uart_data_wr !== exp_q[hold_at]) hold_bad++;
          @(posedge clk); #1;
        end
        bus.uart_full = 1'b0;
      end else bus.uart_full = rand_bp ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (done_cnt != d0) break;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dump_timeout: got no done after 4000 cycles, required a done pulse");
    end
    bus.uart_full = 1'b0;
    bus.start     = 1'b0;
    n   = got.size() - base;
    bad = -1;
    for (int j = 0; j < n; j++)
      if (j >= exp_q.size() || got[base+j] !== exp_q[j]) begin
        bad = j;
        break;
      end
    dd = done_cnt - d0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 4;
    if (bus.uart_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", bus.uart_wr); end
    if (bus.uart_data_wr !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.uart_data_wr); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst_n = 1'b1;
  endtask

  task automatic test_regs();
    int base, st, n, bad, dd, hb;
    load_content(0);
    regs[1] = 32'h12345678;
    drive_content();
    build_exp(2'b00);
    run_dump(2'b00, 0, -1, 0, 0, base, st, n, bad, dd, hb);
    n_cmp += 10;
    if (n !== RC * BPW + CK) begin n_bad++; $display("FAIL regs_count: got %0d want %0d", n, RC * BPW + CK); end
    if (bad !== -1) begin n_bad++; $display("FAIL regs_stream: first bad byte %0d got %h want %h", bad, got[base+bad], exp_q[bad]); end
    if (wr_cyc[base] !== st + 2) begin n_bad++; $display("FAIL regs_latency: first strobe cycle %0d want %0d", wr_cyc[base], st + 2); end
    if (wr_cyc[base+n-1] - wr_cyc[base] !== n - 1) begin n_bad++; $display("FAIL regs_gapless: span %0d want %0d", wr_cyc[base+n-1] - wr_cyc[base], n - 1); end
    if (got[base+4] !== 8'h12) begin n_bad++; $display("FAIL regs_b4: got %h want 12", got[base+4]); end
    if (got[base+5] !== 8'h34) begin n_bad++; $display("FAIL regs_b5: got %h want 34", got[base+5]); end
    if (got[base+6] !== 8'h56) begin n_bad++; $display("FAIL regs_b6: got %h want 56", got[base+6]); end
    if (got[base+7] !== 8'h78) begin n_bad++; $display("FAIL regs_b7: got %h want 78", got[base+7]); end
    if (done_cyc !== wr_cyc[base+n-1] + 1) begin n_bad++; $display("FAIL regs_done_time: got cycle %0d want %0d", done_cyc, wr_cyc[base+n-1] + 1); end
    if (dd !== 1) begin n_bad++; $display("FAIL regs_done_count: got %0d want 1", dd); end
  endtask

  task automatic test_backpressure();
    int base, st, n, bad, dd, hb;
    load_content(1);
    drive_content();
    build_exp(2'b01);
    run_dump(2'b01, 0, 20, 0, 0, base, st, n, bad, dd, hb);
    n_cmp += 4;
    if (hb !== 0) begin n_bad++; $display("FAIL bp_hold: %0d hold cycles wrong got strobe/byte, want 0", hb); end
    if (n !== MC * BPW + CK) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", n, MC * BPW + CK); end
    if (bad !== -1) begin n_bad++; $display("FAIL bp_stream: first bad byte %0d got %h want %h", bad, got[base+bad], exp_q[bad]); end
    if (dd !== 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", dd); end
  endtask

  task automatic test_snapshot();
    int base, st, n, bad, dd, hb;
    load_content(1);
    regs[0] = 32'hAABBCCDD;
    drive_content();
    build_exp(2'b00);
    run_dump(2'b00, 0, -1, 1, 0, base, st, n, bad, dd, hb);
    n_cmp += 5;
    if (got[base+0] !== 8'hAA) begin n_bad++; $display("FAIL snap_b0: got %h want aa", got[base+0]); end
    if (got[base+1] !== 8'hBB) begin n_bad++; $display("FAIL snap_b1: got %h want bb", got[base+1]); end
    if (got[base+2] !== 8'hCC) begin n_bad++; $display("FAIL snap_b2: got %h want cc", got[base+2]); end
    if (got[base+3] !== 8'hDD) begin n_bad++; $display("FAIL snap_b3: got %h want dd", got[base+3]); end
    if (bad !== -1 || n !== exp_q.size()) begin n_bad++; $display("FAIL snap_stream: count %0d first bad %0d, want %0d and -1", n, bad, exp_q.size()); end
  endtask

  task automatic test_both_busy_ignore();
    int base, st, n, bad, dd, hb, nb0;
    load_content(1);
    drive_content();
    build_exp(2'b10);
    nb0 = wr_nobusy;
    run_dump(2'b10, 0, -1, 0, 1, base, st, n, bad, dd, hb);
    n_cmp += 4;
    if (n !== (RC + MC) * BPW + 2 * CK) begin n_bad++; $display("FAIL both_count: got %0d want %0d", n, (RC + MC) * BPW + 2 * CK); end
    if (bad !== -1) begin n_bad++; $display("FAIL both_stream: first bad byte %0d got %h want %h", bad, got[base+bad], exp_q[bad]); end
    if (dd !== 1) begin n_bad++; $display("FAIL both_done_count: got %0d want 1", dd); end
    if (wr_nobusy - nb0 !== 0) begin n_bad++; $display("FAIL both_busy: %0d strobes without busy, want 0", wr_nobusy - nb0); end
  endtask

  task automatic test_async_reset();
    int base, st, n, bad, dd, hb, d0;
    load_content(1);
    drive_content();
    build_exp(2'b00);
    base = got.size();
    d0   = done_cnt;
    start_dump(2'b00, st);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (got.size() - base >= 50) break;
    end
    n_cmp += 5;
    if (got.size() - base !== 50) begin n_bad++; $display("FAIL arst_reach: got %0d bytes want 50", got.size() - base); end
    #2;
    rst_n = 1'b0;
    #1;
    if (bus.uart_wr !== 1'b0) begin n_bad++; $display("FAIL arst_wr: got %b want 0", bus.uart_wr); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL arst_done: got %b want 0", bus.done); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    if (done_cnt !== d0) begin n_bad++; $display("FAIL arst_no_done: got %0d done pulses want 0", done_cnt - d0); end
    run_dump(2'b00, 0, -1, 0, 0, base, st, n, bad, dd, hb);
    n_cmp += 2;
    if (n !== exp_q.size()) begin n_bad++; $display("FAIL arst_redump_count: got %0d want %0d", n, exp_q.size()); end
    if (bad !== -1) begin n_bad++; $display("FAIL arst_redump_stream: first bad byte %0d got %h want %h", bad, got[base+bad], exp_q[bad]); end
  endtask

  task automatic test_random();
    int base, st, n, bad, dd, hb;
    logic [1:0] s;
    for (int it = 0; it < 6; it++) begin
      load_content(1);
      drive_content();
      s = 2'($urandom_range(0, 3));
      build_exp(s);
      run_dump(s, 1, -1, 0, 0, base, st, n, bad, dd, hb);
      n_cmp += 3;
      if (n !== exp_q.size()) begin n_bad++; $display("FAIL rand%0d_count sel=%b: got %0d want %0d", it, s, n, exp_q.size()); end
      if (bad !== -1) begin n_bad++; $display("FAIL rand%0d_stream sel=%b: first bad byte %0d got %h want %h", it, s, bad, got[base+bad], exp_q[bad]); end
      if (dd !== 1) begin n_bad++; $display("FAIL rand%0d_done sel=%b: got %0d want 1", it, s, dd); end
    end
  endtask

`ifdef DUMP_CHECKSUM_EN
  task automatic test_checksum();
    int base, st, n, bad, dd, hb;
    load_content(0);
    regs[0] = 32'h000000FF;
    regs[1] = 32'h0F000000;
    drive_content();
    build_exp(2'b00);
    run_dump(2'b00, 0, -1, 0, 0, base, st, n, bad, dd, hb);
    n_cmp += 2;
    if (n !== RC * BPW + 1) begin n_bad++; $display("FAIL ck_count: got %0d want %0d", n, RC * BPW + 1); end
    if (got[base+n-1] !== 8'hF0) begin n_bad++; $display("FAIL ck_byte: got %h want f0", got[base+n-1]); end
  endtask
`endif

  initial begin
    bus.start             = 1'b0;
    bus.sel               = 2'b00;
    bus.uart_full         = 1'b0;
    bus.registers_content = '0;
    bus.memory_content    = '0;
    test_reset();
    test_regs();
    test_backpressure();
    test_snapshot();
    test_both_busy_ignore();
    test_async_reset();
    test_random();
`ifdef DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dump_serializer.md
Name: dump_serializer

Overview:
Consumer of the MIPS core's flattened register-bank and data-memory content buses. Serializes a snapshot of them into bytes for the UART TX FIFO.
Sits between mips/debugger outputs and the uart write port. The debugger issues a start plus a section select; this block owns the byte stream and the TX-full backpressure handshake.
Snapshot-on-start guarantees a coherent dump even if the core keeps running.

Parameters:
DATA_BUS_SIZE, 32, width of one register / memory slot in bits (multiple of UART_DATA_BITS)
REG_COUNT, 32, number of registers in i_registers_content
MEM_COUNT, 32, number of data-memory slots in i_memory_content
UART_DATA_BITS, 8, byte width sent to UART

Ports:
i_clk  in  1  system clock (wiz_clk domain)
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  start request, sampled only in IDLE
i_select  in  2  00 registers, 01 memory, 10 registers then memory, 11 treated as 10
i_registers_content  in  REG_COUNT*DATA_BUS_SIZE  flattened register bank, word k at bits [k*DATA_BUS_SIZE +: DATA_BUS_SIZE]
i_memory_content  in  MEM_COUNT*DATA_BUS_SIZE  flattened data memory, same packing
i_uart_full  in  1  UART TX FIFO full
o_uart_wr  out  1  write strobe to UART TX FIFO, one cycle per byte
o_uart_data_wr  out  UART_DATA_BITS  byte presented with o_uart_wr
o_busy  out  1  high from snapshot through last byte
o_done  out  1  one-cycle pulse after the final byte is written

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; o_uart_wr=0, o_uart_data_wr=0, o_busy=0, o_done=0; byte counter, section flag and snapshot cleared.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - i_start=1 latches i_select, then goes to LOAD.
  - i_start=0 stays in IDLE.
  - Bytes emitted: 00 -> REG_COUNT*4; 01 -> MEM_COUNT*4; 10/11 -> both sections, registers first.
- LOAD (1 cycle):
  - Copies the selected content bus(es) into an internal snapshot; o_busy goes 1; next state SEND.
  - Content changes after LOAD do not affect the output.
- SEND:
  - o_uart_wr = !i_uart_full (combinational from state and i_uart_full). o_uart_data_wr = current snapshot byte.
  - On a cycle with o_uart_wr=1 the byte counter advances. With i_uart_full=0 the throughput is one byte per cycle.
  - With i_uart_full=1: no strobe, counter frozen, same byte re-presented.
  - Byte order: word index 0 first. Within a word, most significant byte first.
  - When the last byte of the last section is written, next state DONE.
- DONE (1 cycle): o_done=1, o_busy=0, then IDLE. A new i_start is accepted on the following cycle.
- i_start while not in IDLE: ignored, no queuing.
- Byte counter width: clog2((REG_COUNT+MEM_COUNT)*DATA_BUS_SIZE/UART_DATA_BITS + 2). No wrap within a dump.
- Reset mid-SEND: the transfer aborts immediately. No o_done. The partial stream is the host's problem.
- o_uart_wr is never high outside SEND.

Optional Feature:
DUMP_CHECKSUM_EN
- Defined: after each section's data bytes, one extra byte is written. It is the XOR of every data byte of that section, computed over the snapshot as bytes are sent. Select 10 therefore emits 2*4*32+2 = 258 bytes.
- The checksum byte obeys the same i_uart_full backpressure.
- Undefined: no checksum bytes; counts as stated in Behaviour.

Test Plan:
- Regs dump, no backpressure: word1=0x12345678, others 0, i_select=00, pulse i_start -> o_uart_wr high 128 consecutive cycles starting 2 cycles after start; bytes 4..7 = 0x12,0x34,0x56,0x78; o_done one cycle after last byte.
- Backpressure: memory dump, force i_uart_full=1 for 10 cycles at byte 20 -> no strobe during hold; byte 20 re-presented and written when full drops; total exactly 128 strobes.
- Snapshot coherence: change i_registers_content word0 from 0xAABBCCDD to 0 one cycle after LOAD -> first four bytes still 0xAA,0xBB,0xCC,0xDD.
- Both sections plus busy-ignore: i_select=10, re-pulse i_start mid-stream -> exactly 256 bytes (regs then mem), a single o_done, o_busy high throughout.
- Async reset mid-SEND: assert i_reset=0 at byte 50 between clock edges -> o_uart_wr, o_busy go 0 immediately; no o_done; after release, a new dump starts from byte 0.
- DUMP_CHECKSUM_EN: regs dump, word0=0x000000FF, word1=0x0F000000, rest 0 -> 129 bytes, final byte 0xF0.
